// File: rtl/clock_pkg.sv
// Shared mode encodings, BCD limits and the two-digit BCD increment used by the timekeeping datapath.
package clock_pkg;

  localparam logic [1:0] MODE_RUN    = 2'b00;
  localparam logic [1:0] MODE_SET_HR = 2'b01;
  localparam logic [1:0] MODE_SET_MN = 2'b10;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD register: load has priority over increment; increment at max wraps to min.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic [7:0] max,
  input  logic [7:0] min,
  output logic [7:0] q,
  output logic       wrap
);

  assign wrap = (q == max);

  always_ff @(posedge clk) begin
    if (rst)      q <= RST_VAL;
    else if (ld)  q <= ld_val;
    else if (inc) q <= wrap ? min : bcd_inc(q);
  end

endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss timekeeper with synchronised 1 Hz tick and two-button time setting.
module time_keeper
  import clock_pkg::*;
#(
  parameter bit          H24         = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] mn_t,
  output logic [3:0] mn_o,
  output logic [3:0] sc_t,
  output logic [3:0] sc_o,
  output logic       pm,
  output logic [1:0] mode,
  output logic       sec_pulse
);

  localparam logic [7:0] HR_MAX = H24 ? HR24_MAX : HR12_MAX;
  localparam logic [7:0] HR_MIN = H24 ? 8'h00 : HR12_MIN;
  localparam logic [7:0] HR_RST = H24 ? 8'h00 : HR12_MAX;

  logic [2:0] raw;
  logic [2:0] ev;
  logic       tick, mode_ev, inc_ev;

  assign raw = {btn_inc, btn_mode, clk_1hz};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk) begin
      if (rst) begin
        stages <= '0;
        prev   <= 1'b0;
      end else begin
        stages <= {stages[SYNC_STAGES-2:0], raw[g]};
        prev   <= stages[SYNC_STAGES-1];
      end
    end

    assign ev[g] = stages[SYNC_STAGES-1] & ~prev;
  end

  assign tick    = ev[0];
  assign mode_ev = ev[1];
  assign inc_ev  = ev[2];

  logic [1:0] mode_q;
  logic       in_run, in_set_hr, in_set_mn;

  assign in_run    = (mode_q == MODE_RUN);
  assign in_set_hr = (mode_q == MODE_SET_HR);
  assign in_set_mn = (mode_q == MODE_SET_MN);

  logic [7:0] sec_q, min_q, hr_q;
  logic       sec_wrap, min_wrap, unused_hr_wrap;
  logic       sec_inc, sec_clr, min_carry, min_inc, hr_inc;

  // mode_ev suppresses every other event in its cycle; set-mode minute wraps never reach hours.
  assign sec_inc   = in_run & tick & ~mode_ev;
  assign sec_clr   = in_run & mode_ev;
  assign min_carry = sec_inc & sec_wrap;
  assign min_inc   = min_carry | (in_set_mn & inc_ev & ~mode_ev);
  assign hr_inc    = (min_carry & min_wrap) | (in_set_hr & inc_ev & ~mode_ev);

  bcd2_counter #(.RST_VAL(8'h00)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc    (sec_inc),
    .ld     (sec_clr),
    .ld_val (8'h00),
    .max    (SEC_MAX),
    .min    (8'h00),
    .q      (sec_q),
    .wrap   (sec_wrap)
  );

  bcd2_counter #(.RST_VAL(8'h00)) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc    (min_inc),
    .ld     (1'b0),
    .ld_val (8'h00),
    .max    (MIN_MAX),
    .min    (8'h00),
    .q      (min_q),
    .wrap   (min_wrap)
  );

  bcd2_counter #(.RST_VAL(HR_RST)) u_hr (
    .clk    (clk),
    .rst    (rst),
    .inc    (hr_inc),
    .ld     (1'b0),
    .ld_val (8'h00),
    .max    (HR_MAX),
    .min    (HR_MIN),
    .q      (hr_q),
    .wrap   (unused_hr_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_RUN;
    end else begin
      case (mode_q)
        MODE_RUN:    if (mode_ev) mode_q <= MODE_SET_HR;
        MODE_SET_HR: if (mode_ev) mode_q <= MODE_SET_MN;
        MODE_SET_MN: if (mode_ev) mode_q <= MODE_RUN;
        default:                  mode_q <= MODE_RUN;
      endcase
    end
  end

  logic pm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q      <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      pm_q      <= pm_q ^ (!H24 && hr_inc && (hr_q == 8'h11));
      sec_pulse <= sec_inc;
    end
  end

  assign pm   = pm_q;
  assign mode = mode_q;
  assign hr_t = hr_q[7:4];
  assign hr_o = hr_q[3:0];
  assign mn_t = min_q[7:4];
  assign mn_o = min_q[3:0];
  assign sc_t = sec_q[7:4];
  assign sc_o = sec_q[3:0];

endmodule
